// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared types and constants for the PS/2 keyboard front end
package ps2_kbd_pkg;

    // Frame receiver states: start bit seen, eight data bits, parity, stop.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    // Set-2 prefix and modifier scan codes.
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Hack special key codes.
    localparam logic [15:0] KEY_NEWLINE   = 16'd128;
    localparam logic [15:0] KEY_BACKSPACE = 16'd129;
    localparam logic [15:0] KEY_LEFT      = 16'd130;
    localparam logic [15:0] KEY_UP        = 16'd131;
    localparam logic [15:0] KEY_RIGHT     = 16'd132;
    localparam logic [15:0] KEY_DOWN      = 16'd133;
    localparam logic [15:0] KEY_HOME      = 16'd134;
    localparam logic [15:0] KEY_END       = 16'd135;
    localparam logic [15:0] KEY_PGUP      = 16'd136;
    localparam logic [15:0] KEY_PGDN      = 16'd137;
    localparam logic [15:0] KEY_INSERT    = 16'd138;
    localparam logic [15:0] KEY_DELETE    = 16'd139;
    localparam logic [15:0] KEY_ESC       = 16'd140;
    localparam logic [15:0] KEY_F1        = 16'd141;
    localparam logic [15:0] KEY_F2        = 16'd142;
    localparam logic [15:0] KEY_F3        = 16'd143;
    localparam logic [15:0] KEY_F4        = 16'd144;
    localparam logic [15:0] KEY_F5        = 16'd145;
    localparam logic [15:0] KEY_F6        = 16'd146;
    localparam logic [15:0] KEY_F7        = 16'd147;
    localparam logic [15:0] KEY_F8        = 16'd148;
    localparam logic [15:0] KEY_F9        = 16'd149;
    localparam logic [15:0] KEY_F10       = 16'd150;
    localparam logic [15:0] KEY_F11       = 16'd151;
    localparam logic [15:0] KEY_F12       = 16'd152;

    // True when data byte plus parity bit contain an odd number of ones.
    function automatic logic odd_parity(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_scancode_map.sv
// rtl/ps2_scancode_map.sv - Set-2 scan code to Hack key code lookup
module ps2_scancode_map
    import ps2_kbd_pkg::*;
(
    input  logic        ext,
    input  logic [7:0]  code,
    input  logic        shift,
    output logic [15:0] key
);

    // Pure table lookup; anything not listed maps to 0 (ignored by the decoder).
    always_comb begin
        key = 16'd0;
        if (ext) begin
            case (code)
                8'h6B:   key = KEY_LEFT;
                8'h75:   key = KEY_UP;
                8'h74:   key = KEY_RIGHT;
                8'h72:   key = KEY_DOWN;
                8'h6C:   key = KEY_HOME;
                8'h69:   key = KEY_END;
                8'h7D:   key = KEY_PGUP;
                8'h7A:   key = KEY_PGDN;
                8'h70:   key = KEY_INSERT;
                8'h71:   key = KEY_DELETE;
                default: key = 16'd0;
            endcase
        end else begin
            case (code)
                // Letters are always reported upper case.
                8'h1C:   key = 16'h0041;
                8'h32:   key = 16'h0042;
                8'h21:   key = 16'h0043;
                8'h23:   key = 16'h0044;
                8'h24:   key = 16'h0045;
                8'h2B:   key = 16'h0046;
                8'h34:   key = 16'h0047;
                8'h33:   key = 16'h0048;
                8'h43:   key = 16'h0049;
                8'h3B:   key = 16'h004A;
                8'h42:   key = 16'h004B;
                8'h4B:   key = 16'h004C;
                8'h3A:   key = 16'h004D;
                8'h31:   key = 16'h004E;
                8'h44:   key = 16'h004F;
                8'h4D:   key = 16'h0050;
                8'h15:   key = 16'h0051;
                8'h2D:   key = 16'h0052;
                8'h1B:   key = 16'h0053;
                8'h2C:   key = 16'h0054;
                8'h3C:   key = 16'h0055;
                8'h2A:   key = 16'h0056;
                8'h1D:   key = 16'h0057;
                8'h22:   key = 16'h0058;
                8'h35:   key = 16'h0059;
                8'h1A:   key = 16'h005A;
                // Top-row digits and their shifted symbols.
                8'h45:   key = shift ? 16'h0029 : 16'h0030;
                8'h16:   key = shift ? 16'h0021 : 16'h0031;
                8'h1E:   key = shift ? 16'h0040 : 16'h0032;
                8'h26:   key = shift ? 16'h0023 : 16'h0033;
                8'h25:   key = shift ? 16'h0024 : 16'h0034;
                8'h2E:   key = shift ? 16'h0025 : 16'h0035;
                8'h36:   key = shift ? 16'h005E : 16'h0036;
                8'h3D:   key = shift ? 16'h0026 : 16'h0037;
                8'h3E:   key = shift ? 16'h002A : 16'h0038;
                8'h46:   key = shift ? 16'h0028 : 16'h0039;
                8'h29:   key = 16'h0020;
                8'h5A:   key = KEY_NEWLINE;
                8'h66:   key = KEY_BACKSPACE;
                8'h76:   key = KEY_ESC;
                8'h05:   key = KEY_F1;
                8'h06:   key = KEY_F2;
                8'h04:   key = KEY_F3;
                8'h0C:   key = KEY_F4;
                8'h03:   key = KEY_F5;
                8'h0B:   key = KEY_F6;
                8'h83:   key = KEY_F7;
                8'h0A:   key = KEY_F8;
                8'h01:   key = KEY_F9;
                8'h09:   key = KEY_F10;
                8'h78:   key = KEY_F11;
                8'h07:   key = KEY_F12;
                default: key = 16'd0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 frame receiver and make/break decoder for the Hack keyboard register
module ps2_keyboard
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keyboard,
    output logic        scan_valid,
    output logic [7:0]  scan_code,
    output logic        frame_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    // Synchronisers and edge detector.
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   ps2_clk_s, ps2_data_s, sample;

    // Frame receiver.
    frame_state_t      state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              parity_q, parity_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [7:0]        scan_code_q, scan_code_d;
    logic              scan_valid_q, scan_valid_d;
    logic              frame_err_q, frame_err_d;

    // Decoder.
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic              shift_l_q, shift_l_d;
    logic              shift_r_q, shift_r_d;
    logic [8:0]        last_key_q, last_key_d;
    logic [15:0]       keyboard_q, keyboard_d;
    logic [15:0]       mapped;

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign sample     = clk_prev_q & ~ps2_clk_s;

    // Shift raw lines through the synchroniser and remember last synced clock level.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = ps2_clk_s;
    end

    // Frame FSM: collect start, 8 data bits, parity and stop; watchdog aborts stalled frames.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        parity_d     = parity_q;
        wd_cnt_d     = '0;
        scan_code_d  = scan_code_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample && !ps2_data_s) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (sample) begin
                    shreg_d   = {ps2_data_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    parity_d = ps2_data_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    if (ps2_data_s && odd_parity({shreg_q, parity_q})) begin
                        scan_code_d  = shreg_q;
                        scan_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Counter runs only mid-frame and restarts on every sample.
        if (state_q != IDLE && !sample) begin
            if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = IDLE;
                frame_err_d = 1'b1;
                shreg_d     = 8'd0;
                bit_cnt_d   = 3'd0;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
        end
    end

    ps2_scancode_map u_map (
        .ext   (ext_q),
        .code  (scan_code_q),
        .shift (shift_l_q | shift_r_q),
        .key   (mapped)
    );

    // Decoder: track prefixes and shift, update the held key on make/matching break.
    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        shift_l_d  = shift_l_q;
        shift_r_d  = shift_r_q;
        last_key_d = last_key_q;
        keyboard_d = keyboard_q;
        if (scan_valid_q) begin
            if (scan_code_q == SC_EXT) begin
                ext_d = 1'b1;
            end else if (scan_code_q == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                if (!ext_q && scan_code_q == SC_LSHIFT) begin
                    shift_l_d = !brk_q;
                end else if (!ext_q && scan_code_q == SC_RSHIFT) begin
                    shift_r_d = !brk_q;
                end else if (!brk_q) begin
                    if (mapped != 16'd0) begin
                        keyboard_d = mapped;
                        last_key_d = {ext_q, scan_code_q};
                    end
                end else if ({ext_q, scan_code_q} == last_key_q) begin
                    keyboard_d = 16'd0;
                    last_key_d = 9'd0;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end else if (frame_err_q) begin
            // A lost byte may have been part of a prefixed sequence; drop the prefixes.
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    // State registers; lines reset idle-high so release cannot fake a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            clk_prev_q   <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 8'd0;
            parity_q     <= 1'b0;
            wd_cnt_q     <= '0;
            scan_code_q  <= 8'd0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            shift_l_q    <= 1'b0;
            shift_r_q    <= 1'b0;
            last_key_q   <= 9'd0;
            keyboard_q   <= 16'd0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            parity_q     <= parity_d;
            wd_cnt_q     <= wd_cnt_d;
            scan_code_q  <= scan_code_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            shift_l_q    <= shift_l_d;
            shift_r_q    <= shift_r_d;
            last_key_q   <= last_key_d;
            keyboard_q   <= keyboard_d;
        end
    end

    assign keyboard   = keyboard_q;
    assign scan_valid = scan_valid_q;
    assign scan_code  = scan_code_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - self-checking bench for ps2_keyboard
module tb_ps2_keyboard;

    localparam int TO = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keyboard;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic        frame_err;

    int          total = 0;
    int          bad = 0;
    int          sv_cnt = 0;
    int          fe_cnt = 0;
    logic [7:0]  last_sc = 8'd0;

    typedef struct packed {
        logic [7:0]  code;
        logic        badp;
        logic [15:0] kb;
    } vec_t;
    vec_t vecs [$];

    // Reference model state.
    logic        m_ext, m_brk, m_shl, m_shr;
    logic [8:0]  m_last;
    logic [15:0] m_kb;

    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] shift_ch [10]  = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
    logic [7:0] fkey_sc [12]   = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
    logic [7:0] nav_sc [10]    = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
    logic [7:0] pool [24]      = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h1E, 8'h45, 8'h29, 8'h5A, 8'h66, 8'h76,
                                   8'h05, 8'h07, 8'h83, 8'h12, 8'h59, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h6B,
                                   8'h71, 8'h0E, 8'hE0, 8'hF0};

    ps2_keyboard #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keyboard   (keyboard),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (scan_valid) begin
            sv_cnt  <= sv_cnt + 1;
            last_sc <= scan_code;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cycles(4);
        ps2_clk = 1'b0;
        wait_cycles(8);
        ps2_clk = 1'b1;
        wait_cycles(4);
    endtask

    task automatic send_byte(input logic [7:0] c, input logic bp);
        logic [10:0] f;
        f = {1'b1, (~^c) ^ bp, c, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i]);
    endtask

    task automatic run_frame(input logic [7:0] c, input logic bp, input logic [15:0] exp_kb, input string tag);
        int sv0, fe0;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_byte(c, bp);
        wait_cycles(6);
        @(negedge clk);
        check({tag, ":kb"}, keyboard, exp_kb);
        check({tag, ":valid"}, sv_cnt - sv0, bp ? 0 : 1);
        check({tag, ":err"}, fe_cnt - fe0, bp ? 1 : 0);
        if (!bp) check({tag, ":code"}, last_sc, c);
    endtask

    function automatic logic [15:0] model_map(input logic e, input logic [7:0] c, input logic sh);
        logic [15:0] r;
        r = 16'd0;
        if (e) begin
            for (int i = 0; i < 10; i++) if (nav_sc[i] == c) r = 16'(130 + i);
        end else begin
            for (int i = 0; i < 26; i++) if (letter_sc[i] == c) r = 16'(65 + i);
            for (int i = 0; i < 10; i++) if (digit_sc[i] == c) r = sh ? {8'h00, shift_ch[i]} : 16'(48 + i);
            for (int i = 0; i < 12; i++) if (fkey_sc[i] == c) r = 16'(141 + i);
            if (c == 8'h29) r = 16'h0020;
            if (c == 8'h5A) r = 16'd128;
            if (c == 8'h66) r = 16'd129;
            if (c == 8'h76) r = 16'd140;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_last = 9'd0; m_kb = 16'd0;
    endtask

    task automatic model_byte(input logic [7:0] c);
        logic [15:0] mv;
        if (c == 8'hE0) m_ext = 1;
        else if (c == 8'hF0) m_brk = 1;
        else begin
            if (!m_ext && c == 8'h12) m_shl = !m_brk;
            else if (!m_ext && c == 8'h59) m_shr = !m_brk;
            else begin
                mv = model_map(m_ext, c, m_shl || m_shr);
                if (!m_brk && mv != 16'd0) begin
                    m_kb = mv;
                    m_last = {m_ext, c};
                end else if (m_brk && {m_ext, c} == m_last) begin
                    m_kb = 16'd0;
                    m_last = 9'd0;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic add(input logic [7:0] c, input logic bp, input logic [15:0] kb);
        vecs.push_back({c, bp, kb});
    endtask

    initial begin
        int sv0, fe0;
        logic [7:0] c;
        logic bp;

        add(8'h1C, 0, 16'h0041); add(8'hF0, 0, 16'h0041); add(8'h1C, 0, 16'h0000);
        add(8'hE0, 0, 16'h0000); add(8'h75, 0, 16'd131);  add(8'hE0, 0, 16'd131);
        add(8'hF0, 0, 16'd131);  add(8'h75, 0, 16'h0000);
        add(8'hE0, 0, 16'h0000); add(8'h75, 0, 16'd131);  add(8'hF0, 0, 16'd131);
        add(8'h1C, 0, 16'd131);  add(8'hE0, 0, 16'd131);  add(8'hF0, 0, 16'd131);
        add(8'h75, 0, 16'h0000);
        add(8'h16, 1, 16'h0000); add(8'h16, 0, 16'h0031); add(8'hF0, 0, 16'h0031);
        add(8'h16, 0, 16'h0000);
        add(8'h12, 0, 16'h0000); add(8'h16, 0, 16'h0021); add(8'hF0, 0, 16'h0021);
        add(8'h12, 0, 16'h0021); add(8'hF0, 0, 16'h0021); add(8'h16, 0, 16'h0000);
        add(8'h59, 0, 16'h0000); add(8'h1E, 0, 16'h0040); add(8'hF0, 0, 16'h0040);
        add(8'h59, 0, 16'h0040); add(8'h76, 0, 16'd140);  add(8'hF0, 0, 16'd140);
        add(8'h76, 0, 16'h0000); add(8'h83, 0, 16'd147);  add(8'hF0, 0, 16'd147);
        add(8'h83, 0, 16'h0000);

        reset = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(10);
        @(negedge clk);
        check("rst_kb", keyboard, 16'h0000);
        check("rst_valid", scan_valid, 0);
        check("rst_code", scan_code, 8'h00);
        check("rst_err", frame_err, 0);
        wait_cycles(1);
        reset = 1'b1;
        wait_cycles(1000);
        @(negedge clk);
        check("idle_kb", keyboard, 16'h0000);
        check("idle_valid_pulses", sv_cnt, 0);
        check("idle_err_pulses", fe_cnt, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_frame(vecs[i].code, vecs[i].badp, vecs[i].kb, $sformatf("vec%0d", i));
        end

        // Stalled frame: start bit plus three data bits, then silence.
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        wait_cycles(TO + 100);
        @(negedge clk);
        check("timeout_err", fe_cnt - fe0, 1);
        check("timeout_valid", sv_cnt - sv0, 0);
        check("timeout_kb", keyboard, 16'h0000);
        run_frame(8'h29, 0, 16'h0020, "after_to");
        run_frame(8'hF0, 0, 16'h0020, "after_to_f0");
        run_frame(8'h29, 0, 16'h0000, "after_to_rel");

        // Reset in the middle of a frame.
        run_frame(8'h1C, 0, 16'h0041, "pre_rst");
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        reset = 1'b0;
        wait_cycles(3);
        @(negedge clk);
        check("midrst_kb", keyboard, 16'h0000);
        check("midrst_code", scan_code, 8'h00);
        check("midrst_valid", scan_valid, 0);
        check("midrst_err", frame_err, 0);
        wait_cycles(1);
        reset = 1'b1;
        wait_cycles(5);
        run_frame(8'h1C, 0, 16'h0041, "post_rst");
        run_frame(8'hF0, 0, 16'h0041, "post_rst_f0");
        run_frame(8'h1C, 0, 16'h0000, "post_rst_rel");

        // Randomised byte stream against the reference model, from a fresh reset.
        reset = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(3);
        model_reset();
        for (int i = 0; i < 60; i++) begin
            c = pool[$urandom_range(0, 23)];
            bp = ($urandom_range(0, 9) == 0);
            if (bp) begin
                m_ext = 0;
                m_brk = 0;
            end else begin
                model_byte(c);
            end
            run_frame(c, bp, m_kb, $sformatf("rnd%0d_%02h", i, c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
